// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, state encoding and ctrl bit positions for control_sequencer.
// Single-step build: define SINGLE_STEP_EN.
package control_sequencer_pkg;

  localparam int CTRL_W = 20;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_SHR  = 5'b00101;
  localparam logic [4:0] OPC_SHL  = 5'b00110;
  localparam logic [4:0] OPC_AND  = 5'b00111;
  localparam logic [4:0] OPC_OR   = 5'b01000;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    T0     = 4'd0,
    T1     = 4'd1,
    T2     = 4'd2,
    T3     = 4'd3,
    T4     = 4'd4,
    T5     = 4'd5,
    T6     = 4'd6,
    T7     = 4'd7,
    S_HALT = 4'd8
  } tstate_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_R, C_ADDI, C_NOP, C_HALT, C_ILL
  } cls_t;

  localparam int PC_OUT   = 0;
  localparam int MAR_IN   = 1;
  localparam int INC_PC   = 2;
  localparam int Z_IN     = 3;
  localparam int ZLOW_OUT = 4;
  localparam int PC_IN    = 5;
  localparam int READ     = 6;
  localparam int WRITE    = 7;
  localparam int MDR_IN   = 8;
  localparam int MDR_OUT  = 9;
  localparam int IR_IN    = 10;
  localparam int GRA      = 11;
  localparam int GRB      = 12;
  localparam int GRC      = 13;
  localparam int R_IN     = 14;
  localparam int R_OUT    = 15;
  localparam int BA_OUT   = 16;
  localparam int C_OUT    = 17;
  localparam int Y_IN     = 18;
  localparam int SPARE    = 19;

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts stalled cycles of a memory wait and flags the final allowed stall.
// Single-step build: define SINGLE_STEP_EN.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic rdy,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt <= '0;
    end else if (start && !rdy) begin
      if (cnt != 8'hFF) cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  // cnt holds stalls already seen, so this cycle is stall number cnt+1
  assign expired = start && !rdy && (cnt >= 8'(LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer with fetch, decode and memory waits.
// Single-step build: define SINGLE_STEP_EN (adds the step input).
module control_sequencer #(
  parameter int OP_W        = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CTRL_W      = control_sequencer_pkg::CTRL_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       ir,
  input  logic              mem_rdy,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [CTRL_W-1:0] ctrl,
  output logic [OP_W-1:0]   alu_op,
  output logic [3:0]        tstate,
  output logic              run,
  output logic              illegal,
  output logic              mem_err
);
  import control_sequencer_pkg::*;

  tstate_t         state, nxt;
  logic [OP_W-1:0] op, op_n;
  cls_t            cls;
  logic            waiting, expired, adv;
  logic            unused_ir;

`ifdef SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign unused_ir = ^ir[31-OP_W:0];

  function automatic cls_t classify(input logic [OP_W-1:0] o);
    cls_t c;
    c = C_ILL;
    if (o == OP_W'(OPC_LD)) c = C_LD;
    else if (o == OP_W'(OPC_LDI)) c = C_LDI;
    else if (o == OP_W'(OPC_ST)) c = C_ST;
    else if (o >= OP_W'(OPC_ADD) && o <= OP_W'(OPC_OR)) c = C_R;
    else if (o == OP_W'(OPC_ADDI)) c = C_ADDI;
    else if (o == OP_W'(OPC_NOP)) c = C_NOP;
    else if (o == OP_W'(OPC_HALT)) c = C_HALT;
    return c;
  endfunction

  function automatic logic [CTRL_W-1:0] strobes(input tstate_t s, input cls_t c);
    logic [CTRL_W-1:0] v;
    logic mem_op, reg_op;
    v = '0;
    mem_op = (c == C_LD) || (c == C_LDI) || (c == C_ST);
    reg_op = (c == C_R) || (c == C_ADDI);
    unique case (s)
      T0: begin v[PC_OUT] = 1'b1; v[MAR_IN] = 1'b1; v[INC_PC] = 1'b1; v[Z_IN] = 1'b1; end
      T1: begin v[ZLOW_OUT] = 1'b1; v[PC_IN] = 1'b1; v[READ] = 1'b1; v[MDR_IN] = 1'b1; end
      T2: begin v[MDR_OUT] = 1'b1; v[IR_IN] = 1'b1; end
      T3: begin
        if (mem_op) begin v[GRB] = 1'b1; v[BA_OUT] = 1'b1; v[Y_IN] = 1'b1; end
        if (reg_op) begin v[GRB] = 1'b1; v[R_OUT] = 1'b1; v[Y_IN] = 1'b1; end
      end
      T4: begin
        v[Z_IN] = 1'b1;
        if (c == C_R) begin v[GRC] = 1'b1; v[R_OUT] = 1'b1; end
        else v[C_OUT] = 1'b1;
      end
      T5: begin
        v[ZLOW_OUT] = 1'b1;
        if (c == C_LD || c == C_ST) v[MAR_IN] = 1'b1;
        else begin v[GRA] = 1'b1; v[R_IN] = 1'b1; end
      end
      T6: begin
        v[MDR_IN] = 1'b1;
        if (c == C_LD) v[READ] = 1'b1;
        else begin v[GRA] = 1'b1; v[R_OUT] = 1'b1; end
      end
      T7: begin
        v[MDR_OUT] = 1'b1;
        if (c == C_LD) begin v[GRA] = 1'b1; v[R_IN] = 1'b1; end
        else v[WRITE] = 1'b1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [OP_W-1:0] alu_sel(input tstate_t s, input cls_t c,
                                              input logic [OP_W-1:0] o);
    logic [OP_W-1:0] a;
    a = '0;
    if (s == T0) a = OP_W'(OPC_ADD);
    if (s == T4) a = (c == C_R) ? o : OP_W'(OPC_ADD);
    return a;
  endfunction

  // the opcode is latched on the T2->T3 edge and held for the rest of the instruction
  assign op_n = (state == T2) ? ir[31 -: OP_W] : op;
  assign cls  = classify(op_n);
  assign waiting = (state == T1) || (state == T6 && cls == C_LD) ||
                   (state == T7 && cls == C_ST);

  always_comb begin
    nxt = state;
    unique case (state)
      T0: nxt = T1;
      T1: nxt = T2;
      T2: nxt = T3;
      T3: begin
        unique case (cls)
          C_LD, C_LDI, C_ST, C_R, C_ADDI: nxt = T4;
          C_HALT: nxt = S_HALT;
          default: nxt = T0;
        endcase
      end
      T4: nxt = T5;
      T5: nxt = (cls == C_LD || cls == C_ST) ? T6 : T0;
      T6: nxt = T7;
      T7: nxt = T0;
      default: nxt = S_HALT;
    endcase
    if (waiting && !mem_rdy) nxt = expired ? S_HALT : state;
  end

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .clear   (clear),
    .start   (waiting),
    .rdy     (mem_rdy),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state   <= T0;
      op      <= '0;
      ctrl    <= '0;
      alu_op  <= '0;
      illegal <= 1'b0;
      mem_err <= 1'b0;
    end else if (adv) begin
      state   <= nxt;
      op      <= op_n;
      ctrl    <= strobes(nxt, cls);
      alu_op  <= alu_sel(nxt, cls, op_n);
      illegal <= (nxt == T3) && (cls == C_ILL);
      if (expired) mem_err <= 1'b1;
    end else begin
      illegal <= 1'b0;
    end
  end

  assign tstate = state;
  assign run    = (state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Random instruction stream against a per-instruction micro-step table model.
// Single-step build: define SINGLE_STEP_EN.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam int TMO = 15;
  localparam logic [4:0] ADDC = 5'd3;

  logic              clock;
  logic              clear;
  logic [31:0]       ir;
  logic              mem_rdy;
  logic [CTRL_W-1:0] ctrl;
  logic [4:0]        alu_op;
  logic [3:0]        tstate;
  logic              run;
  logic              illegal;
  logic              mem_err;

  control_sequencer #(.OP_W(5), .MEM_TIMEOUT(TMO), .CTRL_W(CTRL_W)) dut (
    .clock   (clock),
    .clear   (clear),
    .ir      (ir),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl),
    .alu_op  (alu_op),
    .tstate  (tstate),
    .run     (run),
    .illegal (illegal),
    .mem_err (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  st;
    logic [19:0] c;
    logic [4:0]  a;
    logic        ill;
    logic        err;
    logic        rdy;
  } cyc_t;

  cyc_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   first, halted, err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [19:0] b(input int i0, input int i1 = -1,
                                    input int i2 = -1, input int i3 = -1);
    logic [19:0] v;
    v = '0;
    v[i0] = 1'b1;
    if (i1 >= 0) v[i1] = 1'b1;
    if (i2 >= 0) v[i2] = 1'b1;
    if (i3 >= 0) v[i3] = 1'b1;
    return v;
  endfunction

  task automatic put(input logic [3:0] s, input logic [19:0] c, input logic [4:0] a,
                     input bit il, input int r);
    cyc_t e;
    e.st = s; e.c = c; e.a = a; e.ill = il; e.err = err;
    e.rdy = (r < 0) ? 1'($urandom) : r[0];
    q.push_back(e);
  endtask

  // d stall cycles then the ready cycle; d >= TMO means memory never answers
  task automatic put_wait(input logic [3:0] s, input logic [19:0] c, input int d);
    if (d >= TMO) begin
      for (int i = 0; i < TMO; i++) put(s, c, 0, 0, 0);
      halted = 1; err = 1;
    end else begin
      for (int i = 0; i < d; i++) put(s, c, 0, 0, 0);
      put(s, c, 0, 0, 1);
    end
  endtask

  task automatic put_halt(input int n);
    for (int i = 0; i < n; i++) put(4'd8, '0, 0, 0, -1);
  endtask

  task automatic instr(input logic [4:0] op, input int d1, input int d2);
    bit rt;
    rt = (op >= 5'd3 && op <= 5'd8);
    put(0, first ? 20'd0 : b(PC_OUT, MAR_IN, INC_PC, Z_IN), ADDC, 0, -1);
    first = 0;
    put_wait(1, b(ZLOW_OUT, PC_IN, READ, MDR_IN), d1);
    if (halted) return;
    put(2, b(MDR_OUT, IR_IN), 0, 0, -1);
    if (op <= 5'd2) put(3, b(GRB, BA_OUT, Y_IN), 0, 0, -1);
    else if (rt || op == 5'd12) put(3, b(GRB, R_OUT, Y_IN), 0, 0, -1);
    else begin
      put(3, '0, 0, !(op == 5'd26 || op == 5'd27), -1);
      if (op == 5'd27) halted = 1;
      return;
    end
    if (rt) put(4, b(GRC, R_OUT, Z_IN), op, 0, -1);
    else put(4, b(C_OUT, Z_IN), ADDC, 0, -1);
    if (op != 5'd0 && op != 5'd2) begin
      put(5, b(ZLOW_OUT, GRA, R_IN), 0, 0, -1);
      return;
    end
    put(5, b(ZLOW_OUT, MAR_IN), 0, 0, -1);
    if (op == 5'd0) begin
      put_wait(6, b(READ, MDR_IN), d2);
      if (halted) return;
      put(7, b(MDR_OUT, GRA, R_IN), 0, 0, -1);
    end else begin
      put(6, b(GRA, R_OUT, MDR_IN), 0, 0, -1);
      put_wait(7, b(MDR_OUT, WRITE), d2);
    end
  endtask

  task automatic run_q(input int stop_st);
    cyc_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check("tstate", 32'(tstate), 32'(e.st));
      check("ctrl", 32'(ctrl), 32'(e.c));
      check("illegal", 32'(illegal), 32'(e.ill));
      check("run", 32'(run), 32'(e.st != 4'd8));
      check("mem_err", 32'(mem_err), 32'(e.err));
      if (e.c[Z_IN]) check("alu_op", 32'(alu_op), 32'(e.a));
      if (32'(e.st) == stop_st) begin
        q.delete();
        return;
      end
      mem_rdy = e.rdy;
      @(negedge clock);
    end
  endtask

  task automatic check_reset();
    check("rst_tstate", 32'(tstate), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_alu", 32'(alu_op), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_run", 32'(run), 32'd1);
  endtask

  task automatic do_reset();
    clear = 1'b0;
    mem_rdy = 1'($urandom);
    @(negedge clock);
    clear = 1'b1;
    first = 1; halted = 0; err = 0;
    check_reset();
  endtask

  task automatic go(input logic [31:0] iv, input int d1, input int d2);
    ir = iv;
    instr(iv[31:27], d1, d2);
    run_q(-1);
  endtask

  initial begin
    logic [4:0] op;
    clear = 1'b0;
    ir = '0;
    mem_rdy = 1'b0;
    @(negedge clock);
    do_reset();

    go(32'h0088_0005, 0, 0);
    go({5'd2, 27'h123_4567}, 0, 3);
    go({5'd3, 27'h55_aaaa}, 1, 0);
    go({5'd31, 27'h0}, 0, 0);
    go({5'd26, 27'h7}, 2, 0);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      go({op, 27'($urandom)}, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    ir = {5'd27, 27'h0};
    instr(5'd27, 1, 0);
    put_halt(20);
    run_q(-1);

    do_reset();
    ir = {5'd0, 27'h0};
    instr(5'd0, 20, 0);
    put_halt(5);
    run_q(-1);

    do_reset();
    ir = {5'd0, 27'h42};
    instr(5'd0, 0, 4);
    run_q(6);
    clear = 1'b0;
    mem_rdy = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    first = 1; halted = 0; err = 0;
    check_reset();
    go({5'd2, 27'h9}, 1, 2);
    go({5'd12, 27'h9}, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OP_W, default 5: opcode width, taken from ir[31:31-OP_W+1].
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_rdy, range 1..255.
REQ-003 Parameter CTRL_W, default 20: width of the ctrl bus; bit indices come from the shared package.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 clear  in  1  reset, synchronous and active-low.
REQ-006 ir  in  32  current instruction register contents.
REQ-007 mem_rdy  in  1  memory completes the current Read or Write in this cycle.
REQ-008 ctrl  out  CTRL_W  one-hot-per-signal datapath strobes: PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, spare.
REQ-009 alu_op  out  OP_W  ALU operation select; valid whenever Zin is asserted.
REQ-010 tstate  out  4  current state encoding, for debug.
REQ-011 run  out  1  high while the sequencer is not in HALT.
REQ-012 illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
REQ-013 mem_err  out  1  sticky flag: a memory wait exceeded MEM_TIMEOUT.

Function
REQ-014 States: T0..T7 and HALT; one state per cycle unless waiting on mem_rdy.
REQ-015 Fetch sequence:
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin; hold T1 until mem_rdy.
- T2: MDRout, IRin.
REQ-016 Decode happens in T3 from ir; ctrl for T3 onward depends on the opcode.
REQ-017 ld (00000):
- T3: Grb, BAout, Yin.
- T4: Cout, Zin, alu_op=ADD.
- T5: Zlowout, MARin.
- T6: Read, MDRin; wait for mem_rdy.
- T7: MDRout, Gra, Rin; then T0.
REQ-018 ldi (00001): T3 and T4 as ld; T5: Zlowout, Gra, Rin; then T0.
REQ-019 st (00010):
- T3..T5 as ld.
- T6: Gra, Rout, MDRin.
- T7: MDRout, Write; wait for mem_rdy; then T0.
REQ-020 R-type, opcodes 00011..01000 (add, sub, shr, shl, and, or):
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, Zin, alu_op=opcode.
- T5: Zlowout, Gra, Rin; then T0.
REQ-021 addi (01100): T3 as R-type; T4: Cout, Zin, alu_op=ADD; T5 as R-type.
REQ-022 halt (11011): enter HALT; ctrl all zero; run=0; remain in HALT until clear.
REQ-023 nop (11010): return from T3 to T0 with ctrl all zero.
REQ-024 Any other opcode: illegal=1 for the T3 cycle; ctrl all zero; next state T0.
REQ-025 Memory waits:
- Read or Write stays asserted until the cycle in which mem_rdy=1, inclusive.
- A wait counter counts the stalled cycles.
- If the count reaches MEM_TIMEOUT with no mem_rdy: set mem_err and go to HALT.
REQ-026 mem_rdy outside a wait state is ignored.
REQ-027 ctrl is registered: it changes only on clock edges and is glitch-free.
REQ-028 Read and Write are never asserted in the same cycle.

Reset
REQ-029 With clear=0 at a rising edge, on the next cycle:
- state=T0, ctrl=0, alu_op=0, illegal=0, mem_err=0, run=1, wait counter=0.
REQ-030 clear asserted mid-instruction or during a memory wait aborts the instruction immediately; no Write is issued after reset.

Configuration
REQ-031 Macro SINGLE_STEP_EN.
- When defined: an added input step (1 bit) gates all advancement; the state advances one step per cycle with step=1 and holds ctrl otherwise.
- A memory wait still requires both step and mem_rdy.
- When undefined: the step port does not exist and the sequencer free-runs.

Structure
REQ-032 Package control_sequencer_pkg holds:
- opcode constants;
- the state enum;
- ctrl bit-index localparams;
- CTRL_W.
REQ-033 Sub-module mem_wait_timer holds the wait counter and the timeout compare, with inputs start, rdy and clear and output expired.

Verification
REQ-034 Fetch then ld, ir=0x0088_0005, mem_rdy=1 immediately -> T0..T7 in 8 cycles; MDRout+Gra+Rin at T7.
REQ-035 st with mem_rdy delayed 3 cycles -> Write held for 4 cycles in T7, then T0.
REQ-036 add (opcode 00011) -> alu_op=00011 together with Zin at T4; T0 after T5.
REQ-037 Opcode 11111 -> illegal pulse for 1 cycle, ctrl=0, then T0; halt opcode -> run=0 and HALT held for 20 cycles.
REQ-038 Read with mem_rdy never asserted and MEM_TIMEOUT=15 -> mem_err=1 and HALT after 15 stall cycles.
REQ-039 clear=0 during T6 of ld -> next cycle T0 with ctrl=0; mem_err clears.
